// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// Length, state and owner encodings plus the alignment rule.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    LEN_NONE = 2'b00,
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_WORD = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  len;
    logic        rs;
    logic [31:0] addr;
    logic [31:0] wd;
  } mem_req_t;

  function automatic logic access_bad(
    input logic [1:0] len,
    input logic [1:0] a
  );
    logic r;
    case (len)
      LEN_BYTE: r = 1'b0;
      LEN_HALF: r = a[0];
      LEN_WORD: r = (a != 2'b00);
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_counter.sv
// Access latency counter: load, decrement, zero flag.
// Ports: clk/rst, load_i+value_i, dec_i, zero_o.
module mem_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// Ports: SYS_*, FETCH_* requester, DATA_* requester, MEM_* memory.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        FETCH_req,
  input  logic [31:0] FETCH_address,
  output logic        FETCH_ready,
  output logic [31:0] FETCH_instruction,
  output logic        FETCH_error,
  input  logic        DATA_req,
  input  logic        DATA_write,
  input  logic [1:0]  DATA_length,
  input  logic        DATA_signed,
  input  logic [31:0] DATA_address,
  input  logic [31:0] DATA_write_data,
  output logic        DATA_ready,
  output logic [31:0] DATA_read_data,
  output logic        DATA_error,
  output logic        MEM_enable,
  output logic        MEM_write_enable,
  output logic [1:0]  MEM_length,
  output logic        MEM_read_signed,
  output logic [31:0] MEM_address,
  output logic [31:0] MEM_write_data,
  input  logic [31:0] MEM_read_data
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  mem_req_t    mreq_q, mreq_d;
  logic        men_q, men_d;
  logic        fready_q, fready_d;
  logic        ferr_q, ferr_d;
  logic [31:0] finstr_q, finstr_d;
  logic        dready_q, dready_d;
  logic        derr_q, derr_d;
  logic [31:0] drdata_q, drdata_d;

  logic arb, grant, bad;
  logic fetch_win, data_win;
  logic in_acc, cnt_zero, cnt_load;
  logic [31:0] cap;

  assign arb = (state_q == ST_IDLE)
            || (state_q == ST_RESP);
  assign in_acc = (state_q == ST_ACCESS);

  // Fetch wins when alone or once data has
  // used up its streak while fetch waited.
  assign fetch_win = FETCH_req && (!DATA_req
    || streak_q == 4'(MAX_DATA_STREAK));
  assign data_win = DATA_req && !fetch_win;
  assign grant = fetch_win || data_win;

  assign bad = fetch_win
    ? access_bad(LEN_WORD, FETCH_address[1:0])
    : access_bad(DATA_length, DATA_address[1:0]);

  assign cnt_load = arb && grant && !bad;
  assign cap = mreq_q.we ? 32'h0 : MEM_read_data;

  mem_latency_counter #(.W(4)) u_cnt (
    .clk     (SYS_clk),
    .rst     (SYS_reset),
    .load_i  (cnt_load),
    .value_i (4'(MEM_LATENCY - 1)),
    .dec_i   (in_acc),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_FETCH;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (!grant)   state_d = ST_IDLE;
        else if (bad) state_d = ST_RESP;
        else          state_d = ST_ACCESS;
        if (grant)
          owner_d = fetch_win ? OWN_FETCH : OWN_DATA;
        if (!FETCH_req || fetch_win)
          streak_d = '0;
        else if (data_win)
          streak_d = streak_q + 4'd1;
      end
      ST_ACCESS: begin
        if (cnt_zero) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    men_d    = 1'b0;
    mreq_d   = '0;
    fready_d = 1'b0;
    ferr_d   = 1'b0;
    finstr_d = finstr_q;
    dready_d = 1'b0;
    derr_d   = 1'b0;
    drdata_d = drdata_q;
    unique case (1'b1)
      cnt_load: begin
        men_d = 1'b1;
        if (fetch_win) begin
          mreq_d.len  = LEN_WORD;
          mreq_d.addr = FETCH_address;
        end else begin
          mreq_d.we   = DATA_write;
          mreq_d.len  = DATA_length;
          mreq_d.rs   = DATA_signed && !DATA_write;
          mreq_d.addr = DATA_address;
          mreq_d.wd   = DATA_write
                      ? DATA_write_data : 32'h0;
        end
      end
      (arb && grant && bad): begin
        if (fetch_win) begin
          fready_d = 1'b1;
          ferr_d   = 1'b1;
          finstr_d = 32'h0;
        end else begin
          dready_d = 1'b1;
          derr_d   = 1'b1;
          drdata_d = 32'h0;
        end
      end
      (in_acc && !cnt_zero): begin
        men_d  = 1'b1;
        mreq_d = mreq_q;
      end
      (in_acc && cnt_zero): begin
        if (owner_q == OWN_FETCH) begin
          fready_d = 1'b1;
          finstr_d = cap;
        end else begin
          dready_d = 1'b1;
          drdata_d = cap;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      men_q    <= 1'b0;
      mreq_q   <= '0;
      fready_q <= 1'b0;
      ferr_q   <= 1'b0;
      finstr_q <= '0;
      dready_q <= 1'b0;
      derr_q   <= 1'b0;
      drdata_q <= '0;
    end else begin
      men_q    <= men_d;
      mreq_q   <= mreq_d;
      fready_q <= fready_d;
      ferr_q   <= ferr_d;
      finstr_q <= finstr_d;
      dready_q <= dready_d;
      derr_q   <= derr_d;
      drdata_q <= drdata_d;
    end
  end

  assign FETCH_ready       = fready_q;
  assign FETCH_error       = ferr_q;
  assign FETCH_instruction = finstr_q;
  assign DATA_ready        = dready_q;
  assign DATA_error        = derr_q;
  assign DATA_read_data    = drdata_q;
  assign MEM_enable        = men_q;
  assign MEM_write_enable  = mreq_q.we;
  assign MEM_length        = mreq_q.len;
  assign MEM_read_signed   = mreq_q.rs;
  assign MEM_address       = mreq_q.addr;
  assign MEM_write_data    = mreq_q.wd;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter.
// Transaction-timeline reference model with a simple memory.
module tb_memory_port_arbiter;

  localparam int LAT = 2;
  localparam int STREAK = 4;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        FETCH_req;
  logic [31:0] FETCH_address;
  logic        FETCH_ready;
  logic [31:0] FETCH_instruction;
  logic        FETCH_error;
  logic        DATA_req;
  logic        DATA_write;
  logic [1:0]  DATA_length;
  logic        DATA_signed;
  logic [31:0] DATA_address;
  logic [31:0] DATA_write_data;
  logic        DATA_ready;
  logic [31:0] DATA_read_data;
  logic        DATA_error;
  logic        MEM_enable;
  logic        MEM_write_enable;
  logic [1:0]  MEM_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_address;
  logic [31:0] MEM_write_data;
  logic [31:0] MEM_read_data;

  always #5 clk = ~clk;

  memory_port_arbiter #(
    .MEM_LATENCY     (LAT),
    .MAX_DATA_STREAK (STREAK)
  ) dut (
    .SYS_clk           (clk),
    .SYS_reset         (rst),
    .FETCH_req         (FETCH_req),
    .FETCH_address     (FETCH_address),
    .FETCH_ready       (FETCH_ready),
    .FETCH_instruction (FETCH_instruction),
    .FETCH_error       (FETCH_error),
    .DATA_req          (DATA_req),
    .DATA_write        (DATA_write),
    .DATA_length       (DATA_length),
    .DATA_signed       (DATA_signed),
    .DATA_address      (DATA_address),
    .DATA_write_data   (DATA_write_data),
    .DATA_ready        (DATA_ready),
    .DATA_read_data    (DATA_read_data),
    .DATA_error        (DATA_error),
    .MEM_enable        (MEM_enable),
    .MEM_write_enable  (MEM_write_enable),
    .MEM_length        (MEM_length),
    .MEM_read_signed   (MEM_read_signed),
    .MEM_address       (MEM_address),
    .MEM_write_data    (MEM_write_data),
    .MEM_read_data     (MEM_read_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(
    input string        tag,
    input logic [159:0] got,
    input logic [159:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(
    input logic [31:0] a
  );
    return (a * 32'h9E3779B1) ^ 32'h0F0F5A5A;
  endfunction

  function automatic bit is_bad(
    input logic [1:0] len,
    input logic [1:0] a
  );
    return len == 2'b00
        || (len == 2'b10 && a[0])
        || (len == 2'b11 && a != 2'b00);
  endfunction

  function automatic logic [159:0] all_out();
    return {FETCH_ready, FETCH_instruction,
            FETCH_error, DATA_ready,
            DATA_read_data, DATA_error,
            MEM_enable, MEM_write_enable,
            MEM_length, MEM_read_signed,
            MEM_address, MEM_write_data};
  endfunction

  // current granted transaction
  bit          g_on, g_fetch, g_err;
  int          g_s;
  logic        g_we, g_rs;
  logic [1:0]  g_len;
  logic [31:0] g_addr, g_wd;
  int          streak;
  logic [31:0] e_instr;

  // requester state
  bit          f_pend, f_gnt, d_pend, d_gnt;
  logic [31:0] f_addr, d_addr, d_wd;
  logic        d_we, d_sg;
  logic [1:0]  d_len;
  bit          did_rst;
  int          n_starve;

  initial begin
    int rdy, r;
    bit win, fr, dr, fw, dw;
    logic [68:0] em;
    rst = 1'b1;
    FETCH_req = 0; FETCH_address = 0;
    DATA_req = 0; DATA_write = 0;
    DATA_length = 0; DATA_signed = 0;
    DATA_address = 0; DATA_write_data = 0;
    MEM_read_data = 0;
    g_on = 0; streak = 0; e_instr = 0;
    f_pend = 0; f_gnt = 0;
    d_pend = 0; d_gnt = 0;
    did_rst = 0; n_starve = 0;
    repeat (3) @(negedge clk);
    check("reset_state", all_out(), 160'h0);
    rst = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rdy = !g_on ? -1
          : (g_err ? g_s + 1 : g_s + LAT + 1);
      win = g_on && !g_err
         && c >= g_s + 1 && c <= g_s + LAT;
      em = win ? {1'b1, g_we, g_len, g_rs,
                  g_addr, g_wd} : 69'h0;
      check("mem_bus",
            {MEM_enable, MEM_write_enable,
             MEM_length, MEM_read_signed,
             MEM_address, MEM_write_data}, em);
      fr = g_on && g_fetch && c == rdy;
      dr = g_on && !g_fetch && c == rdy;
      if (fr) e_instr = g_err ? 32'h0 : memf(g_addr);
      check("fetch_ready", FETCH_ready, fr);
      check("fetch_error", FETCH_error, fr && g_err);
      check("fetch_instr", FETCH_instruction, e_instr);
      check("data_ready", DATA_ready, dr);
      check("data_error", DATA_error, dr && g_err);
      if (dr)
        check("data_rdata", DATA_read_data,
              (g_err || g_we) ? 32'h0 : memf(g_addr));

      if (rst) rst = 1'b0;

      if (!did_rst && c > 1500 && win) begin
        rst = 1'b1;
        FETCH_req = 0;
        DATA_req = 0;
        #1;
        check("async_reset", all_out(), 160'h0);
        did_rst = 1;
        g_on = 0; streak = 0; e_instr = 0;
        f_pend = 0; f_gnt = 0;
        d_pend = 0; d_gnt = 0;
        continue;
      end

      MEM_read_data = (win && c == g_s + LAT)
                    ? memf(g_addr) : $urandom;

      if (fr) begin f_pend = 0; f_gnt = 0; end
      if (dr) begin d_pend = 0; d_gnt = 0; end
      if (!f_pend && $urandom_range(0, 99) < 40) begin
        f_pend = 1;
        f_addr = $urandom;
        if ($urandom_range(0, 3) != 0) f_addr[1:0] = 0;
      end
      if (!d_pend && $urandom_range(0, 99) < 85) begin
        d_pend = 1;
        d_we = 1'($urandom);
        d_sg = 1'($urandom);
        d_wd = $urandom;
        d_addr = $urandom;
        if ($urandom_range(0, 3) < 2) d_addr[1:0] = 0;
        r = $urandom_range(0, 9);
        d_len = r == 0 ? 2'b00 : r < 4 ? 2'b01
              : r < 7 ? 2'b10 : 2'b11;
      end
      FETCH_req = f_pend;
      FETCH_address = f_gnt ? $urandom : f_addr;
      DATA_req = d_pend;
      DATA_write = d_gnt ? 1'($urandom) : d_we;
      DATA_signed = d_gnt ? 1'($urandom) : d_sg;
      DATA_length = d_gnt ? 2'($urandom) : d_len;
      DATA_address = d_gnt ? $urandom : d_addr;
      DATA_write_data = d_gnt ? $urandom : d_wd;

      if (!g_on || c == rdy) begin
        g_on = 0;
        fw = f_pend && (!d_pend || streak == STREAK);
        dw = d_pend && !fw;
        if (fw && d_pend) n_starve++;
        if (!f_pend || fw) streak = 0;
        else if (dw) streak++;
        if (fw) begin
          g_on = 1; g_s = c; g_fetch = 1;
          g_err = is_bad(2'b11, f_addr[1:0]);
          g_we = 0; g_rs = 0; g_len = 2'b11;
          g_addr = f_addr; g_wd = 0;
          f_gnt = 1;
        end else if (dw) begin
          g_on = 1; g_s = c; g_fetch = 0;
          g_err = is_bad(d_len, d_addr[1:0]);
          g_we = d_we; g_rs = d_sg && !d_we;
          g_len = d_len; g_addr = d_addr;
          g_wd = d_we ? d_wd : 32'h0;
          d_gnt = 1;
        end
      end
    end

    check("starvation_seen", 160'(n_starve > 0), 160'd1);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
